lap_stopwatch: RTL and testbench

//  Parametrised successor to the single-run stopwatch: mm:ss:cc timer with a lap buffer of configurable depth,

---
 rtl/stopwatch_pkg.sv | 46 ++++
 rtl/mmsscc_counter.sv | 49 ++++
 rtl/lap_stopwatch.sv | 187 ++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg : shared widths, time struct and FSM states for lap_stopwatch
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int CS_W  = 7;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic [MIN_W-1:0] mm;
    logic [SEC_W-1:0] ss;
    logic [CS_W-1:0]  cc;
  } time_t;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One centisecond step with cc->ss->mm carries; the caller handles saturation.
  function automatic time_t time_inc(input time_t t);
    time_t r;
    r = t;
    if (t.cc == CS_W'(99)) begin
      r.cc = '0;
      if (t.ss == SEC_W'(59)) begin
        r.ss = '0;
        r.mm = t.mm + MIN_W'(1);
      end else begin
        r.ss = t.ss + SEC_W'(1);
      end
    end else begin
      r.cc = t.cc + CS_W'(1);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmsscc_counter.sv
// ---------------------------------------------------------------------------
// mmsscc_counter : enable-gated mm:ss:cc counter, clear, saturation at MAX_MIN:59:99
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mmsscc_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic  m_clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clr,
  output time_t count,
  output time_t next_count,
  output logic  max_hit
);

  localparam time_t MAX_T = '{mm: MIN_W'(MAX_MIN), ss: SEC_W'(59), cc: CS_W'(99)};

  logic at_max;

  assign at_max = (count == MAX_T);

  always_comb begin
    next_count = count;
    if (clr) begin
      next_count = '0;
    end else if (en && !at_max) begin
      next_count = time_inc(count);
    end
  end

  // Any enabled tick that lands on (or sits at) the ceiling reports the hit.
  assign max_hit = en & ~clr & (next_count == MAX_T);

  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lap_stopwatch.sv
// ---------------------------------------------------------------------------
// lap_stopwatch : mm:ss:cc stopwatch with lap buffer, ring overwrite and browsing
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = 4,
  parameter int MAX_MIN   = 59,
  parameter int LAP_RING  = 0
) (
  input  logic             m_clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             active,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [CS_W-1:0]  centis,
  output logic [IDX_W-1:0] view_idx,
  output logic [IDX_W-1:0] lap_count,
  output logic             running,
  output logic             saturated
);

  localparam logic [IDX_W-1:0] DEPTH = IDX_W'(LAP_DEPTH);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(LAP_DEPTH - 1);
  localparam int               SLOTS = 2 ** IDX_W;

  state_t           state;
  time_t            live_time;
  time_t            next_time;
  time_t            shown;
  // Sized to the full index range so pointers index it directly; slots at or
  // beyond LAP_DEPTH are never written and stay at their reset value.
  time_t            laps [SLOTS];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W:0]   rd_sum;
  logic             press_ss;
  logic             press_clr;
  logic             press_lap;
  logic             has_laps;
  logic             full;
  logic             ring_ok;
  logic             lap_store;
  logic             lap_flush;
  logic             lap_browse;
  logic             cnt_en;
  logic             cnt_clr;
  logic             max_hit;

  generate
    if (LAP_RING != 0) begin : g_ring
      assign ring_ok = 1'b1;
    end else begin : g_no_ring
      assign ring_ok = 1'b0;
    end
  endgenerate

  // start_stop > clear > lap: at most one press acts per cycle.
  assign press_ss  = active & start_stop;
  assign press_clr = active & clear & ~start_stop;
  assign press_lap = active & lap & ~start_stop & ~clear;

  assign has_laps   = (lap_count != '0);
  assign full       = (lap_count == DEPTH);
  assign lap_store  = press_lap & (state == ST_RUN) & (~full | ring_ok);
  assign lap_browse = press_lap & (state != ST_RUN) & has_laps;
  assign lap_flush  = press_clr & (state != ST_RUN) & has_laps;

  // Counter sees the pre-press state, so a stop press still counts its tick.
  assign cnt_en  = tick_en & (state == ST_RUN);
  assign cnt_clr = press_clr & (state != ST_RUN) & ~has_laps;

  mmsscc_counter #(
    .MAX_MIN (MAX_MIN)
  ) u_counter (
    .m_clk      (m_clk),
    .reset      (reset),
    .en         (cnt_en),
    .clr        (cnt_clr),
    .count      (live_time),
    .next_count (next_time),
    .max_hit    (max_hit)
  );

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == LAST) ? '0 : p + IDX_W'(1);
  endfunction

  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_STOP;
      running   <= 1'b0;
      saturated <= 1'b0;
      view_idx  <= '0;
      lap_count <= '0;
      wr_ptr    <= '0;
      base      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        laps[i] <= '0;
      end
    end else begin
      case (state)
        ST_STOP: begin
          if (press_ss) begin
            state    <= ST_RUN;
            running  <= 1'b1;
            view_idx <= '0;
          end
        end
        ST_RUN: begin
          view_idx <= '0;
          if (press_ss) begin
            state   <= ST_STOP;
            running <= 1'b0;
          end else if (max_hit) begin
            state     <= ST_DONE;
            running   <= 1'b0;
            saturated <= 1'b1;
          end
        end
        ST_DONE: begin
          if (press_clr && !has_laps) begin
            state     <= ST_STOP;
            saturated <= 1'b0;
          end
        end
        default: begin
          state     <= ST_STOP;
          running   <= 1'b0;
          saturated <= 1'b0;
        end
      endcase

      // Store the value visible next cycle, i.e. including a same-cycle tick.
      if (lap_store) begin
        laps[wr_ptr] <= next_time;
        wr_ptr       <= ptr_inc(wr_ptr);
        if (full) begin
          base <= ptr_inc(base);
        end else begin
          lap_count <= lap_count + IDX_W'(1);
        end
      end

      if (lap_flush) begin
        lap_count <= '0;
        view_idx  <= '0;
        wr_ptr    <= '0;
        base      <= '0;
        for (int i = 0; i < SLOTS; i++) begin
          laps[i] <= '0;
        end
      end

      if (lap_browse) begin
        view_idx <= (view_idx == lap_count) ? '0 : view_idx + IDX_W'(1);
      end
    end
  end

  // k-th oldest lap lives at (base + k - 1) mod LAP_DEPTH.
  assign rd_sum = {1'b0, base} + {1'b0, view_idx} - (IDX_W + 1)'(1);
  assign rd_idx = (rd_sum >= {1'b0, DEPTH}) ? IDX_W'(rd_sum - {1'b0, DEPTH})
                                            : rd_sum[IDX_W-1:0];

  always_comb begin
    shown = live_time;
    if (view_idx != '0) begin
      shown = laps[rd_idx];
    end
  end

  assign minutes = shown.mm;
  assign seconds = shown.ss;
  assign centis  = shown.cc;

endmodule

`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
// ---------------------------------------------------------------------------
// tb_lap_stopwatch : directed vectors for three parameterisations of lap_stopwatch
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lap_stopwatch;

  logic m_clk = 1'b0;
  logic reset = 1'b1;
  logic tick_en = 1'b0;
  logic active = 1'b1;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [5:0] a_mm, b_mm, d_mm;
  logic [5:0] a_ss, b_ss, d_ss;
  logic [6:0] a_cc, b_cc, d_cc;
  logic [3:0] a_view, b_view, d_view;
  logic [3:0] a_cnt, b_cnt, d_cnt;
  logic       a_run, b_run, d_run;
  logic       a_sat, b_sat, d_sat;

  int n_checks = 0;
  int n_fail = 0;

  always #5 m_clk = ~m_clk;

  // A: two laps, drop when full, saturates at 01:59:99
  lap_stopwatch #(.LAP_DEPTH(2), .MAX_MIN(1), .LAP_RING(0)) u_a (
    .m_clk(m_clk), .reset(reset), .tick_en(tick_en), .active(active),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .minutes(a_mm), .seconds(a_ss), .centis(a_cc), .view_idx(a_view),
    .lap_count(a_cnt), .running(a_run), .saturated(a_sat));

  // B: two laps, ring overwrite
  lap_stopwatch #(.LAP_DEPTH(2), .MAX_MIN(59), .LAP_RING(1)) u_b (
    .m_clk(m_clk), .reset(reset), .tick_en(tick_en), .active(active),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .minutes(b_mm), .seconds(b_ss), .centis(b_cc), .view_idx(b_view),
    .lap_count(b_cnt), .running(b_run), .saturated(b_sat));

  // D: default parameters
  lap_stopwatch u_d (
    .m_clk(m_clk), .reset(reset), .tick_en(tick_en), .active(active),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .minutes(d_mm), .seconds(d_ss), .centis(d_cc), .view_idx(d_view),
    .lap_count(d_cnt), .running(d_run), .saturated(d_sat));

  typedef struct {
    logic ss;
    logic cl;
    logic lp;
    logic tk;
    logic act;
    int   t;
    int   view;
    int   cnt;
    int   run;
  } vec_t;

  vec_t tbl [14];

  function automatic int tv(input logic [5:0] mm, input logic [5:0] ss, input logic [6:0] cc);
    return int'(mm) * 10000 + int'(ss) * 100 + int'(cc);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic c, input logic l, input logic t);
    start_stop = s;
    clear      = c;
    lap        = l;
    tick_en    = t;
    @(posedge m_clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    tick_en    = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ss    cl    lp    tk    act   time view cnt run
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 0, 1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1, 0, 0, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,  2, 0, 1, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1,  3, 0, 1, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  3, 0, 1, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  2, 1, 1, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  3, 0, 1, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  3, 0, 1, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1,  4, 0, 1, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  5, 0, 1, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  5, 0, 1, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  5, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  0, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  0, 0, 0, 0};

    repeat (3) @(posedge m_clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    chk("reset time", tv(d_mm, d_ss, d_cc), 0);
    chk("reset view", int'(d_view), 0);
    chk("reset lap_count", int'(d_cnt), 0);
    chk("reset running", int'(d_run), 0);
    chk("reset saturated", int'(d_sat), 0);

    for (int i = 0; i < 14; i++) begin
      active = tbl[i].act;
      step(tbl[i].ss, tbl[i].cl, tbl[i].lp, tbl[i].tk);
      active = 1'b1;
      chk($sformatf("vec%0d time", i), tv(d_mm, d_ss, d_cc), tbl[i].t);
      chk($sformatf("vec%0d view", i), int'(d_view), tbl[i].view);
      chk($sformatf("vec%0d lap_count", i), int'(d_cnt), tbl[i].cnt);
      chk($sformatf("vec%0d running", i), int'(d_run), tbl[i].run);
    end

    // Laps at 00:01:00, 00:02:00, 00:03:00
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(100);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(100);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(100);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drop lap_count", int'(a_cnt), 2);
    chk("ring lap_count", int'(b_cnt), 2);
    chk("deep lap_count", int'(d_cnt), 3);
    chk("drop live time", tv(a_mm, a_ss, a_cc), 300);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drop view1 idx", int'(a_view), 1);
    chk("drop view1 time", tv(a_mm, a_ss, a_cc), 100);
    chk("ring view1 time", tv(b_mm, b_ss, b_cc), 200);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drop view2 idx", int'(a_view), 2);
    chk("drop view2 time", tv(a_mm, a_ss, a_cc), 200);
    chk("ring view2 time", tv(b_mm, b_ss, b_cc), 300);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drop view wrap idx", int'(a_view), 0);
    chk("drop live again", tv(a_mm, a_ss, a_cc), 300);
    chk("ring view wrap idx", int'(b_view), 0);
    chk("deep view3 idx", int'(d_view), 3);
    chk("deep view3 time", tv(d_mm, d_ss, d_cc), 300);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush lap_count", int'(a_cnt), 0);
    chk("flush keeps time", tv(a_mm, a_ss, a_cc), 300);
    chk("flush deep view", int'(d_view), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clear time", tv(a_mm, a_ss, a_cc), 0);
    chk("clear running", int'(a_run), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ss+clear running", int'(a_run), 1);
    chk("ss+clear time", tv(a_mm, a_ss, a_cc), 0);

    // Inactive: counting continues, every press is ignored
    active = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step(i % 50 == 0, i % 3 == 0, i % 7 == 0, 1'b1);
    end
    active = 1'b1;
    chk("inactive time", tv(d_mm, d_ss, d_cc), 500);
    chk("inactive running", int'(d_run), 1);
    chk("inactive lap_count", int'(d_cnt), 0);

    // Asynchronous reset mid-cycle
    #3;
    reset = 1'b1;
    #1;
    chk("async reset time", tv(d_mm, d_ss, d_cc), 0);
    chk("async reset running", int'(d_run), 0);
    chk("async reset b time", tv(b_mm, b_ss, b_cc), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("first tick after reset", tv(d_mm, d_ss, d_cc), 1);

    ticks(5999);
    chk("6000 ticks time", tv(d_mm, d_ss, d_cc), 10000);
    chk("6000 ticks running", int'(d_run), 1);
    chk("6000 ticks saturated", int'(d_sat), 0);
    chk("6000 ticks max1 sat", int'(a_sat), 0);

    ticks(5999);
    chk("max time", tv(a_mm, a_ss, a_cc), 15999);
    chk("max saturated", int'(a_sat), 1);
    chk("max running", int'(a_run), 0);
    chk("deep 11999 time", tv(d_mm, d_ss, d_cc), 15999);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold after max", tv(a_mm, a_ss, a_cc), 15999);
    chk("deep carry to 02", tv(d_mm, d_ss, d_cc), 20000);
    ticks(10);
    chk("hold more ticks", tv(a_mm, a_ss, a_cc), 15999);
    chk("hold saturated", int'(a_sat), 1);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("done clear time", tv(a_mm, a_ss, a_cc), 0);
    chk("done clear saturated", int'(a_sat), 0);
    chk("done clear running", int'(a_run), 0);
    chk("run ignores clear", tv(d_mm, d_ss, d_cc), 20010);
    chk("run ignores clear run", int'(d_run), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
